// File: rtl/cacheline_adapter.sv
// Splits arbiter cache-line reads/writes into fixed-length memory bursts.
// One line per request; resp_o pulses one cycle after the last beat.
module cacheline_adapter #(
  parameter int unsigned cacheline_size = 256,
  parameter int unsigned burst_size     = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [cacheline_size-1:0] line_i,
  output logic [cacheline_size-1:0] line_o,
  input  logic [31:0]               address_i,
  input  logic                      read_i,
  input  logic                      write_i,
  output logic                      resp_o,
  input  logic [burst_size-1:0]     burst_i,
  output logic [burst_size-1:0]     burst_o,
  output logic [31:0]               address_o,
  output logic                      read_o,
  output logic                      write_o,
  input  logic                      resp_i
);

  localparam int unsigned Beats      = cacheline_size / burst_size;
  localparam int unsigned CntW       = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned OffsetBits = 5;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [31:0]               addr_q, addr_d;
  logic [cacheline_size-1:0] wline_q, wline_d;
  logic [cacheline_size-1:0] rline_q, rline_d;
  logic                      last_beat;

  assign last_beat = (cnt_q == CntW'(Beats - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    unique case (state_q)
      StIdle: begin
        // Read takes priority when both requests are raised together.
        if (read_i) begin
          addr_d  = address_i;
          cnt_d   = '0;
          state_d = StRead;
        end else if (write_i) begin
          addr_d  = address_i;
          wline_d = line_i;
          cnt_d   = '0;
          state_d = StWrite;
        end
      end
      StRead: begin
        if (resp_i) begin
          rline_d[int'(cnt_q)*burst_size +: burst_size] = burst_i;
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = StDone;
        end
      end
      StWrite: begin
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    read_o    = (state_q == StRead);
    write_o   = (state_q == StWrite);
    resp_o    = (state_q == StDone);
    address_o = '0;
    burst_o   = '0;
    if (read_o || write_o) address_o = {addr_q[31:OffsetBits], {OffsetBits{1'b0}}};
    if (write_o) burst_o = wline_q[int'(cnt_q)*burst_size +: burst_size];
  end

  assign line_o = rline_q;

  // Memory address is line-aligned; the low offset bits are latched but never driven.
  logic unused_addr;
  assign unused_addr = ^addr_q[OffsetBits-1:0];

endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized bench for cacheline_adapter against a line-level transaction model.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int total = 0;
  int bad   = 0;
  logic [255:0] exp_line = '0;

  cacheline_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Idle-state expectations; stray resp_i is driven to show it is ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_read_o", read_o, 0);
      check("idle_write_o", write_o, 0);
      check("idle_resp_o", resp_o, 0);
      check("idle_addr_o", address_o, 0);
      check("idle_burst_o", burst_o, 0);
      check("idle_line_o", line_o, exp_line);
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      read_i  = 1'b0;
      write_i = 1'b0;
      @(posedge clk);
    end
  endtask

  // gap < 0 selects a random 0..2 cycle gap before each beat.
  task automatic do_read(input logic [31:0] a, input logic [255:0] line, input bit both,
                         input bit keep, input int gap);
    int k, w, g;
    @(negedge clk);
    check("rd_start_idle", {resp_o, read_o, write_o}, 0);
    check("rd_start_line", line_o, exp_line);
    read_i    = 1'b1;
    write_i   = both;
    address_i = a;
    line_i    = rand_line();
    resp_i    = $urandom_range(0, 1);
    burst_i   = {$urandom, $urandom};
    @(posedge clk);
    k = 0; w = 0;
    g = (gap < 0) ? $urandom_range(0, 2) : gap;
    while (k < 4) begin
      @(negedge clk);
      check("rd_read_o", read_o, 1);
      check("rd_write_o", write_o, 0);
      check("rd_resp_o", resp_o, 0);
      check("rd_addr_o", address_o, {a[31:5], 5'b0});
      check("rd_burst_o", burst_o, 0);
      if (!keep && $urandom_range(0, 3) == 0) begin
        read_i  = 1'b0;
        write_i = 1'b0;
      end
      address_i = $urandom;
      if (w < g) begin
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        w++;
      end else begin
        resp_i  = 1'b1;
        burst_i = line[k*64 +: 64];
        k++;
        w = 0;
        g = (gap < 0) ? $urandom_range(0, 2) : gap;
      end
      @(posedge clk);
    end
    @(negedge clk);
    resp_i = 1'b0;
    check("rd_done_resp_o", resp_o, 1);
    check("rd_done_rw_o", {read_o, write_o}, 0);
    check("rd_done_addr_o", address_o, 0);
    check("rd_done_line_o", line_o, line);
    exp_line = line;
    if (!keep) begin
      read_i  = 1'b0;
      write_i = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [255:0] line, input int gap);
    int k, w, g;
    @(negedge clk);
    check("wr_start_idle", {resp_o, read_o, write_o}, 0);
    read_i    = 1'b0;
    write_i   = 1'b1;
    address_i = a;
    line_i    = line;
    resp_i    = 1'b0;
    @(posedge clk);
    k = 0; w = 0;
    g = (gap < 0) ? $urandom_range(0, 2) : gap;
    while (k < 4) begin
      @(negedge clk);
      check("wr_write_o", write_o, 1);
      check("wr_read_o", read_o, 0);
      check("wr_resp_o", resp_o, 0);
      check("wr_addr_o", address_o, {a[31:5], 5'b0});
      check("wr_burst_o", burst_o, line[k*64 +: 64]);
      check("wr_line_o", line_o, exp_line);
      if ($urandom_range(0, 3) == 0) write_i = 1'b0;
      address_i = $urandom;
      line_i    = rand_line();
      burst_i   = {$urandom, $urandom};
      if (w < g) begin
        resp_i = 1'b0;
        w++;
      end else begin
        resp_i = 1'b1;
        k++;
        w = 0;
        g = (gap < 0) ? $urandom_range(0, 2) : gap;
      end
      @(posedge clk);
    end
    @(negedge clk);
    resp_i  = 1'b0;
    write_i = 1'b0;
    check("wr_done_resp_o", resp_o, 1);
    check("wr_done_rw_o", {read_o, write_o}, 0);
    check("wr_done_burst_o", burst_o, 0);
    check("wr_done_line_o", line_o, exp_line);
    @(posedge clk);
  endtask

  // Two beats of a read, then reset: the burst is dropped and the buffer cleared.
  task automatic read_abort(input logic [31:0] a);
    @(negedge clk);
    read_i    = 1'b1;
    address_i = a;
    resp_i    = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      @(posedge clk);
    end
    @(negedge clk);
    check("ab_mid_read_o", read_o, 1);
    rst     = 1'b1;
    read_i  = 1'b0;
    resp_i  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("ab_read_o", read_o, 0);
    check("ab_resp_o", resp_o, 0);
    check("ab_line_o", line_o, 0);
    check("ab_addr_o", address_o, 0);
    exp_line = '0;
    @(posedge clk);
  endtask

  initial begin
    logic [255:0] l;
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_outputs", {resp_o, read_o, write_o}, 0);
    check("rst_addr_o", address_o, 0);
    check("rst_burst_o", burst_o, 0);
    check("rst_line_o", line_o, 0);
    @(posedge clk);

    l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_read(32'h0000_1234, l, 1'b0, 1'b0, 0);
    do_write(32'hdead_beef, rand_line(), 2);
    do_read($urandom, rand_line(), 1'b1, 1'b0, -1);
    // Held read: DONE, one IDLE cycle, then the second burst.
    do_read($urandom, rand_line(), 1'b0, 1'b1, 0);
    do_read($urandom, rand_line(), 1'b0, 1'b0, 0);
    read_abort($urandom);
    do_read($urandom, rand_line(), 1'b0, 1'b0, 0);
    idle_cycles(3);
    do_read($urandom, rand_line(), 1'b0, 1'b0, 0);

    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 2))
        0: do_read($urandom, rand_line(), 1'($urandom_range(0, 1)), 1'b0, -1);
        1: do_write($urandom, rand_line(), -1);
        default: idle_cycles($urandom_range(1, 3));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
